wm_phase_timer: RTL and testbench

Phase-duration timer for the washing-machine controller. It watches the controller's `state` output and, on every state change, loads that phase's duration. It counts the duration down in prescaled "second" ticks and returns a one-cycle `sig_Time_Out` pulse to the controller's timeout input. It sits directly beside the `Microcontroller` FSM, consuming its state and producing the timeout that advances it.

---
 rtl/wm_pkg.sv | 14 +
 rtl/wm_tick_gen.sv | 23 ++
 rtl/wm_phase_timer.sv | 70 +++++++
 tb/tb_wm_phase_timer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Washing-machine controller state encodings shared by the controller FSM and
// its phase timer.
package wm_pkg;
  typedef enum logic [3:0] {
    WM_IDLE  = 4'd0,
    WM_READY = 4'd1,
    WM_SOAK  = 4'd2,
    WM_WASH  = 4'd3,
    WM_RINSE = 4'd4,
    WM_SPIN  = 4'd5,
    WM_DONE  = 4'd6,
    WM_FAULT = 4'd7
  } wm_state_t;
endpackage

// File: rtl/wm_tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and flags the wrap cycle as a tick.
module wm_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  // tick is only meaningful while enabled; clear overrides it in the parent
  assign tick = enable && (cnt == W'(DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/wm_phase_timer.sv
// Phase-duration timer: reloads on every controller state change, counts the
// phase down in prescaled ticks and pulses sig_Time_Out once on expiry.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 8,
  parameter int SOAK_T   = 4,
  parameter int WASH_T   = 6,
  parameter int RINSE_T  = 5,
  parameter int SPIN_T   = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       state,
  input  logic             sig_Lid_Closed,
  output logic             sig_Time_Out,
  output logic [CNT_W-1:0] remaining,
  output logic             running
);
  function automatic logic [CNT_W-1:0] duration(input logic [3:0] s);
    case (s)
      WM_SOAK:  return CNT_W'(SOAK_T);
      WM_WASH:  return CNT_W'(WASH_T);
      WM_RINSE: return CNT_W'(RINSE_T);
      WM_SPIN:  return CNT_W'(SPIN_T);
      default:  return '0;
    endcase
  endfunction

  logic [3:0]       prev_state;
  logic             change;
  logic             tick;
  logic [CNT_W-1:0] load_val;

  assign change   = (state != prev_state);
  assign load_val = duration(state);

  wm_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (running && sig_Lid_Closed),
    .clear   (change),
    .tick    (tick)
  );

  // A reload on the same edge as an expiry wins and suppresses the pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_state   <= WM_IDLE;
      remaining    <= '0;
      running      <= 1'b0;
      sig_Time_Out <= 1'b0;
    end else if (change) begin
      prev_state   <= state;
      remaining    <= load_val;
      running      <= (load_val != '0);
      sig_Time_Out <= 1'b0;
    end else begin
      sig_Time_Out <= 1'b0;
      if (tick && remaining != '0) begin
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          running      <= 1'b0;
          sig_Time_Out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer with TICK_DIV=2, WASH_T=3, SPIN_T=2.
module tb_wm_phase_timer;
  import wm_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] state;
  logic       sig_Lid_Closed;
  logic       sig_Time_Out;
  logic [7:0] remaining;
  logic       running;

  int total = 0;
  int bad   = 0;

  wm_phase_timer #(
    .TICK_DIV(2), .CNT_W(8), .SOAK_T(4), .WASH_T(3), .RINSE_T(5), .SPIN_T(2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .state          (state),
    .sig_Lid_Closed (sig_Lid_Closed),
    .sig_Time_Out   (sig_Time_Out),
    .remaining      (remaining),
    .running        (running)
  );

  always #5 clock = ~clock;

  // advance n rising edges, land 1ns after the last one
  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // park in IDLE, then load WASH; returns just after load edge L
  task automatic load_wash();
    state = WM_IDLE;
    edges(1);
    state = WM_WASH;
    edges(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; state = WM_WASH; sig_Lid_Closed = 1'b1;
    edges(3);
    total++; if (sig_Time_Out !== 1'b0) begin bad++; $display("FAIL reset_to got=%0b want=0", sig_Time_Out); end
    total++; if (remaining !== 8'd0) begin bad++; $display("FAIL reset_rem got=%0d want=0", remaining); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_run got=%0b want=0", running); end
    reset_n = 1'b1;
    edges(1);
    total++; if (remaining !== 8'd3) begin bad++; $display("FAIL reset_load_rem got=%0d want=3", remaining); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL reset_load_run got=%0b want=1", running); end
  endtask

  task automatic test_expiry();
    logic [7:0] exp_rem;
    load_wash();
    total++; if (remaining !== 8'd3) begin bad++; $display("FAIL exp_load got=%0d want=3", remaining); end
    for (int k = 1; k <= 6; k++) begin
      edges(1);
      exp_rem = 8'(3 - k / 2);
      total++; if (remaining !== exp_rem) begin bad++; $display("FAIL exp_rem k=%0d got=%0d want=%0d", k, remaining, exp_rem); end
      total++; if (sig_Time_Out !== (k == 6)) begin bad++; $display("FAIL exp_to k=%0d got=%0b want=%0b", k, sig_Time_Out, (k == 6)); end
    end
    edges(1);
    total++; if (sig_Time_Out !== 1'b0) begin bad++; $display("FAIL exp_to_fall got=%0b want=0", sig_Time_Out); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL exp_run got=%0b want=0", running); end
    edges(6);
    total++; if (sig_Time_Out !== 1'b0 || remaining !== 8'd0) begin bad++; $display("FAIL exp_no_repeat to=%0b rem=%0d want 0/0", sig_Time_Out, remaining); end
  endtask

  task automatic test_pause();
    load_wash();
    edges(2);
    total++; if (remaining !== 8'd2) begin bad++; $display("FAIL pause_first_tick got=%0d want=2", remaining); end
    sig_Lid_Closed = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      edges(1);
      total++; if (remaining !== 8'd2 || sig_Time_Out !== 1'b0) begin bad++; $display("FAIL pause_hold k=%0d rem=%0d to=%0b want 2/0", k, remaining, sig_Time_Out); end
    end
    sig_Lid_Closed = 1'b1;
    for (int k = 8; k <= 11; k++) begin
      edges(1);
      total++; if (sig_Time_Out !== (k == 11)) begin bad++; $display("FAIL pause_to k=%0d got=%0b want=%0b", k, sig_Time_Out, (k == 11)); end
    end
    total++; if (remaining !== 8'd0) begin bad++; $display("FAIL pause_end_rem got=%0d want=0", remaining); end
    edges(1);
  endtask

  task automatic test_collision();
    load_wash();
    edges(5);
    state = WM_SPIN;
    edges(1);
    total++; if (sig_Time_Out !== 1'b0) begin bad++; $display("FAIL coll_to got=%0b want=0", sig_Time_Out); end
    total++; if (remaining !== 8'd2 || running !== 1'b1) begin bad++; $display("FAIL coll_load rem=%0d run=%0b want 2/1", remaining, running); end
    for (int k = 1; k <= 4; k++) begin
      edges(1);
      total++; if (sig_Time_Out !== (k == 4)) begin bad++; $display("FAIL coll_spin_to k=%0d got=%0b want=%0b", k, sig_Time_Out, (k == 4)); end
    end
    edges(1);
  endtask

  task automatic test_untimed();
    logic [3:0] codes [3];
    codes[0] = WM_READY; codes[1] = WM_DONE; codes[2] = 4'd15;
    for (int c = 0; c < 3; c++) begin
      state = codes[c];
      for (int k = 0; k < 50; k++) begin
        edges(1);
        total++;
        if (sig_Time_Out !== 1'b0 || running !== 1'b0 || remaining !== 8'd0) begin
          bad++;
          $display("FAIL untimed code=%0d cyc=%0d to=%0b run=%0b rem=%0d want 0/0/0", codes[c], k, sig_Time_Out, running, remaining);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    load_wash();
    edges(2);
    total++; if (remaining !== 8'd2) begin bad++; $display("FAIL arst_pre got=%0d want=2", remaining); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (remaining !== 8'd0 || running !== 1'b0 || sig_Time_Out !== 1'b0) begin bad++; $display("FAIL arst_clear rem=%0d run=%0b to=%0b want 0/0/0", remaining, running, sig_Time_Out); end
    edges(2);
    total++; if (sig_Time_Out !== 1'b0 || remaining !== 8'd0) begin bad++; $display("FAIL arst_hold to=%0b rem=%0d want 0/0", sig_Time_Out, remaining); end
    reset_n = 1'b1;
    edges(1);
    total++; if (remaining !== 8'd3 || running !== 1'b1) begin bad++; $display("FAIL arst_reload rem=%0d run=%0b want 3/1", remaining, running); end
    total++; if (sig_Time_Out !== 1'b0) begin bad++; $display("FAIL arst_no_pulse got=%0b want=0", sig_Time_Out); end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_pause();
    test_collision();
    test_untimed();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
